reg_file_rename: RTL and testbench

- Architectural register file with per-register rename tags for the Tomasulo core.
- Sits at the receiving end of the ROB commit bus; serves operand lookups to the issue stage.
- At issue it marks rd busy with the allocating ROB entry number.
- At commit it writes the retired value and releases the busy mark if the tag still matches.
- On ROB flush it drops every busy mark so operands resolve to committed state.

---
 rtl/reg_file_rename_if.sv | 43 ++++
 rtl/reg_file_rename.sv | 130 +++++++++++++
 tb/tb_reg_file_rename.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/reg_file_rename_if.sv
// Commit/issue/lookup bus between the ROB, the issue stage and the renamed
// architectural register file. The master drives strobes and lookup
// addresses; the register file (slave) returns operand value, busy and tag.
interface reg_file_rename_if #(
    parameter int TAG_W = 5,
    parameter int XLEN  = 32
);
    logic             rdy_in;
    logic             clear_in;
    logic             commit_en_in;
    logic [TAG_W-1:0] commit_rob_in;
    logic [4:0]       commit_rd_in;
    logic [XLEN-1:0]  commit_val_in;
    logic             issue_en_in;
    logic [4:0]       issue_rd_in;
    logic [TAG_W-1:0] issue_rob_in;
    logic [4:0]       rs1_addr_in;
    logic [4:0]       rs2_addr_in;
    logic [XLEN-1:0]  rs1_val_out;
    logic             rs1_busy_out;
    logic [TAG_W-1:0] rs1_tag_out;
    logic [XLEN-1:0]  rs2_val_out;
    logic             rs2_busy_out;
    logic [TAG_W-1:0] rs2_tag_out;

    modport master (
        output rdy_in, clear_in,
        output commit_en_in, commit_rob_in, commit_rd_in, commit_val_in,
        output issue_en_in, issue_rd_in, issue_rob_in,
        output rs1_addr_in, rs2_addr_in,
        input  rs1_val_out, rs1_busy_out, rs1_tag_out,
        input  rs2_val_out, rs2_busy_out, rs2_tag_out
    );

    modport slave (
        input  rdy_in, clear_in,
        input  commit_en_in, commit_rob_in, commit_rd_in, commit_val_in,
        input  issue_en_in, issue_rd_in, issue_rob_in,
        input  rs1_addr_in, rs2_addr_in,
        output rs1_val_out, rs1_busy_out, rs1_tag_out,
        output rs2_val_out, rs2_busy_out, rs2_tag_out
    );
endinterface

// File: rtl/reg_file_rename.sv
// Architectural register file with per-register rename tags.
// Commit writes the retired value and releases the busy mark only when the
// retiring ROB entry is still the newest writer; issue marks rd busy with
// its ROB entry; clear (ROB flush) drops every busy mark.
// Optional macro REGFILE_BYPASS_EN: forward a same-cycle releasing commit
// to the lookup ports so the issue stage need not stall on a collision.

// One architectural register: value, busy mark and producer tag.
module reg_file_rename_entry #(
    parameter int TAG_W = 5,
    parameter int XLEN  = 32
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             rdy_in,
    input  logic             clear_in,
    input  logic             wr_en,
    input  logic [XLEN-1:0]  wr_val,
    input  logic [TAG_W-1:0] rel_rob,
    input  logic             al_en,
    input  logic [TAG_W-1:0] al_rob,
    output logic [XLEN-1:0]  val_q,
    output logic             busy_q,
    output logic [TAG_W-1:0] tag_q
);
    logic rel;

    // Release only if the retiring entry is still the pending writer.
    assign rel = wr_en && busy_q && (tag_q == rel_rob);

    // Commit value, then issue/release of the busy mark, flush wins last.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            val_q  <= '0;
            busy_q <= 1'b0;
            tag_q  <= '0;
        end else if (rdy_in) begin
            if (wr_en)
                val_q <= wr_val;
            if (clear_in) begin
                busy_q <= 1'b0;
            end else if (al_en) begin
                busy_q <= 1'b1;
                tag_q  <= al_rob;
            end else if (rel) begin
                busy_q <= 1'b0;
            end
        end
    end
endmodule

module reg_file_rename #(
    parameter int NUM_REGS = 32,
    parameter int TAG_W    = 5,
    parameter int XLEN     = 32
) (
    input logic              clk_in,
    input logic              rst_n_in,
    reg_file_rename_if.slave bus
);
    logic [NUM_REGS-1:0][XLEN-1:0]  val_q;
    logic [NUM_REGS-1:0]            busy_q;
    logic [NUM_REGS-1:0][TAG_W-1:0] tag_q;

    logic [1:0][4:0]       rd_addr;
    logic [1:0][XLEN-1:0]  rd_val;
    logic [1:0]            rd_busy;
    logic [1:0][TAG_W-1:0] rd_tag;

    genvar i;
    generate
        for (i = 0; i < NUM_REGS; i++) begin : g_reg
            if (i == 0) begin : g_x0
                // x0 is hardwired: never written, never busy.
                assign val_q[i]  = '0;
                assign busy_q[i] = 1'b0;
                assign tag_q[i]  = '0;
            end else begin : g_xn
                localparam logic [4:0] IDX = 5'(i);
                logic wr_en, al_en;
                assign wr_en = bus.commit_en_in && (bus.commit_rd_in == IDX);
                assign al_en = bus.issue_en_in  && (bus.issue_rd_in  == IDX);
                reg_file_rename_entry #(.TAG_W(TAG_W), .XLEN(XLEN)) u_ent (
                    .clk_in   (clk_in),
                    .rst_n_in (rst_n_in),
                    .rdy_in   (bus.rdy_in),
                    .clear_in (bus.clear_in),
                    .wr_en    (wr_en),
                    .wr_val   (bus.commit_val_in),
                    .rel_rob  (bus.commit_rob_in),
                    .al_en    (al_en),
                    .al_rob   (bus.issue_rob_in),
                    .val_q    (val_q[i]),
                    .busy_q   (busy_q[i]),
                    .tag_q    (tag_q[i])
                );
            end
        end
    endgenerate

    assign rd_addr[0] = bus.rs1_addr_in;
    assign rd_addr[1] = bus.rs2_addr_in;

    // Combinational operand lookup, optionally forwarding a releasing commit.
    always_comb begin
        rd_val  = '0;
        rd_busy = '0;
        rd_tag  = '0;
        for (int p = 0; p < 2; p++) begin
            rd_val[p]  = val_q[rd_addr[p]];
            rd_busy[p] = busy_q[rd_addr[p]];
            rd_tag[p]  = tag_q[rd_addr[p]];
`ifdef REGFILE_BYPASS_EN
            if (bus.commit_en_in && (bus.commit_rd_in != 5'd0) &&
                (rd_addr[p] == bus.commit_rd_in) && busy_q[rd_addr[p]] &&
                (tag_q[rd_addr[p]] == bus.commit_rob_in)) begin
                rd_val[p]  = bus.commit_val_in;
                rd_busy[p] = 1'b0;
            end
`endif
        end
    end

    assign bus.rs1_val_out  = rd_val[0];
    assign bus.rs1_busy_out = rd_busy[0];
    assign bus.rs1_tag_out  = rd_tag[0];
    assign bus.rs2_val_out  = rd_val[1];
    assign bus.rs2_busy_out = rd_busy[1];
    assign bus.rs2_tag_out  = rd_tag[1];
endmodule

// File: tb/tb_reg_file_rename.sv
// Bench for reg_file_rename: directed scenarios then random traffic, with
// expected lookups from an array model queued and compared on the falling
// clock edge by an independent monitor.
module tb_reg_file_rename;
    logic clk_in = 1'b0;
    logic rst_n_in = 1'b0;
    always #5 clk_in = ~clk_in;

    reg_file_rename_if #(.TAG_W(5), .XLEN(32)) bus ();
    reg_file_rename #(.NUM_REGS(32), .TAG_W(5), .XLEN(32)) dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .bus      (bus.slave)
    );

    typedef struct {
        string       name;
        logic [31:0] v1; logic b1; logic [4:0] t1;
        logic [31:0] v2; logic b2; logic [4:0] t2;
    } exp_t;
    exp_t exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    // architectural model
    logic [31:0] mval [32];
    logic        mbusy[32];
    logic [4:0]  mtag [32];

    function automatic void model_reset();
        for (int r = 0; r < 32; r++) begin
            mval[r] = '0; mbusy[r] = 1'b0; mtag[r] = '0;
        end
    endfunction

    // expected lookup of one address given the current model and commit bus
    function automatic void model_read(input logic [4:0] a, input logic ce,
            input logic [4:0] crob, input logic [4:0] crd, input logic [31:0] cval,
            output logic [31:0] v, output logic b, output logic [4:0] t);
        v = 32'd0; b = 1'b0; t = 5'd0;
        if (a != 5'd0) begin
            v = mval[a]; b = mbusy[a]; t = mtag[a];
`ifdef REGFILE_BYPASS_EN
            if (ce && crd == a && mbusy[a] && mtag[a] == crob) begin
                v = cval; b = 1'b0;
            end
`endif
        end
    endfunction

    // one cycle: drive inputs, queue expected lookup, advance model on edge
    task automatic cyc(input string nm, input logic rdy, input logic clr,
            input logic ce, input logic [4:0] crob, input logic [4:0] crd,
            input logic [31:0] cval, input logic ie, input logic [4:0] ird,
            input logic [4:0] irob, input logic [4:0] a1, input logic [4:0] a2);
        exp_t e;
        bus.rdy_in = rdy; bus.clear_in = clr;
        bus.commit_en_in = ce; bus.commit_rob_in = crob;
        bus.commit_rd_in = crd; bus.commit_val_in = cval;
        bus.issue_en_in = ie; bus.issue_rd_in = ird; bus.issue_rob_in = irob;
        bus.rs1_addr_in = a1; bus.rs2_addr_in = a2;
        e.name = nm;
        model_read(a1, ce, crob, crd, cval, e.v1, e.b1, e.t1);
        model_read(a2, ce, crob, crd, cval, e.v2, e.b2, e.t2);
        exp_q.push_back(e);
        @(posedge clk_in);
        if (rst_n_in && rdy) begin
            if (ce && crd != 5'd0) begin
                if (mbusy[crd] && mtag[crd] == crob) mbusy[crd] = 1'b0;
                mval[crd] = cval;
            end
            if (clr) begin
                for (int r = 0; r < 32; r++) mbusy[r] = 1'b0;
            end else if (ie && ird != 5'd0) begin
                mbusy[ird] = 1'b1; mtag[ird] = irob;
            end
        end
        #1;
    endtask

    task automatic look(input string nm, input logic [4:0] a1, input logic [4:0] a2);
        cyc(nm, 1, 0, 0, 0, 0, 0, 0, 0, 0, a1, a2);
    endtask

    // monitor: compare DUT lookups against queued expectations
    always @(negedge clk_in) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_cmp++;
            if (bus.rs1_val_out !== e.v1 || bus.rs1_busy_out !== e.b1 || bus.rs1_tag_out !== e.t1) begin
                n_bad++;
                $display("FAIL %s rs1: got val=%h busy=%b tag=%0d, want val=%h busy=%b tag=%0d",
                         e.name, bus.rs1_val_out, bus.rs1_busy_out, bus.rs1_tag_out, e.v1, e.b1, e.t1);
            end
            n_cmp++;
            if (bus.rs2_val_out !== e.v2 || bus.rs2_busy_out !== e.b2 || bus.rs2_tag_out !== e.t2) begin
                n_bad++;
                $display("FAIL %s rs2: got val=%h busy=%b tag=%0d, want val=%h busy=%b tag=%0d",
                         e.name, bus.rs2_val_out, bus.rs2_busy_out, bus.rs2_tag_out, e.v2, e.b2, e.t2);
            end
        end
    end

    initial begin
        logic [4:0] crd, ird, crob, a1, a2;
        model_reset();
        @(posedge clk_in); #1;
        // reset state, with busy traffic that must be ignored
        cyc("reset", 1, 0, 1, 5'd1, 5'd5, 32'h77, 1, 5'd5, 5'd3, 5'd5, 5'd0);
        rst_n_in = 1'b1;
        look("post_reset", 5'd5, 5'd0);

        // issue then commit release
        cyc("issue3", 1, 0, 0, 0, 0, 0, 1, 5'd3, 5'd7, 5'd3, 5'd0);
        look("busy3", 5'd3, 5'd0);
        cyc("commit3", 1, 0, 1, 5'd7, 5'd3, 32'h1234, 0, 0, 0, 5'd3, 5'd3);
        look("released3", 5'd3, 5'd3);

        // older commit must not release a younger writer
        cyc("iss4a", 1, 0, 0, 0, 0, 0, 1, 5'd4, 5'd2, 5'd4, 5'd0);
        cyc("iss4b", 1, 0, 0, 0, 0, 0, 1, 5'd4, 5'd9, 5'd4, 5'd0);
        cyc("cm4old", 1, 0, 1, 5'd2, 5'd4, 32'hAA, 0, 0, 0, 5'd4, 5'd0);
        look("young4", 5'd4, 5'd0);

        // same-cycle matching commit and issue on one register
        cyc("iss3", 1, 0, 0, 0, 0, 0, 1, 5'd3, 5'd7, 5'd0, 5'd3);
        cyc("cm_iss3", 1, 0, 1, 5'd7, 5'd3, 32'h5678, 1, 5'd3, 5'd12, 5'd3, 5'd0);
        look("reiss3", 5'd3, 5'd0);

        // commit + clear + discarded issue
        cyc("iss6", 1, 0, 0, 0, 0, 0, 1, 5'd6, 5'd1, 5'd6, 5'd0);
        cyc("iss8", 1, 0, 0, 0, 0, 0, 1, 5'd8, 5'd2, 5'd6, 5'd8);
        cyc("clr", 1, 1, 1, 5'd0, 5'd5, 32'h55, 1, 5'd9, 5'd4, 5'd6, 5'd8);
        look("clr68", 5'd6, 5'd8);
        look("clr59", 5'd5, 5'd9);

        // lookup collision with a releasing commit
        cyc("iss3c", 1, 0, 0, 0, 0, 0, 1, 5'd3, 5'd7, 5'd0, 5'd0);
        cyc("bypass", 1, 0, 1, 5'd7, 5'd3, 32'hBEEF, 0, 0, 0, 5'd3, 5'd0);
        look("after_bp", 5'd3, 5'd0);

        // x0 never written or busy
        cyc("x0", 1, 0, 1, 5'd3, 5'd0, 32'd5, 1, 5'd0, 5'd4, 5'd0, 5'd0);
        look("x0rd", 5'd0, 5'd0);

        // rdy low holds all state
        cyc("stall", 0, 1, 1, 5'd0, 5'd3, 32'hDEAD, 1, 5'd3, 5'd1, 5'd3, 5'd4);
        look("held", 5'd3, 5'd4);

        // random traffic over a small register window to force collisions
        for (int n = 0; n < 2000; n++) begin
            crd = 5'($urandom_range(0, 7));
            ird = 5'($urandom_range(0, 7));
            a1  = 5'($urandom_range(0, 7));
            a2  = ($urandom_range(0, 3) == 0) ? crd : 5'($urandom_range(0, 7));
            crob = ($urandom_range(0, 2) != 0) ? mtag[crd] : 5'($urandom);
            cyc("rand", ($urandom_range(0, 7) != 0), ($urandom_range(0, 19) == 0),
                ($urandom_range(0, 1) == 1), crob, crd, $urandom,
                ($urandom_range(0, 1) == 1), ird, 5'($urandom), a1, a2);
        end

        // asynchronous reset mid-cycle clears before the next edge
        look("pre_arst", 5'd1, 5'd2);
        rst_n_in = 1'b0;
        model_reset();
        look("arst", 5'd1, 5'd2);
        rst_n_in = 1'b1;
        look("post_arst", 5'd3, 5'd4);

        @(negedge clk_in); #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
